// File: rtl/pdh_pkg.sv
// Shared definitions for the ADC capture block: default sample width and
// the capture FSM state encoding visible on state_o.
package pdh_pkg;

  localparam int ADC_DATA_WIDTH_DEFAULT = 14;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } capture_state_t;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// Read-first on same-address collisions; contents are never reset.
module capture_ram #(
  parameter int DATA_WIDTH = 28,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      r_mem[wr_addr_i] <= wr_data_i;
    end
  end

  // Output register holds its value between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (rd_en_i) begin
      r_rd_data <= r_mem[rd_addr_i];
    end
  end

  assign rd_data_o = r_rd_data;

endmodule

// File: rtl/adc_capture.sv
// Two-channel ADC snapshot capture with decimation into a 2**ADDR_WIDTH deep buffer.
// Define PDH_CAPTURE_TRIG_EN to wait for a channel-A rising crossing before capturing.
module adc_capture
  import pdh_pkg::*;
#(
  parameter int ADC_DATA_WIDTH = ADC_DATA_WIDTH_DEFAULT,
  parameter int ADDR_WIDTH     = 10,
  parameter int DECIM_WIDTH    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ADC_DATA_WIDTH-1:0]   adc_dat_a_i,
  input  logic [ADC_DATA_WIDTH-1:0]   adc_dat_b_i,
  input  logic                        arm_i,
  input  logic                        abort_i,
  input  logic [DECIM_WIDTH-1:0]      decim_i,
  input  logic [ADC_DATA_WIDTH-1:0]   trig_level_i,
  input  logic                        rd_en_i,
  input  logic [ADDR_WIDTH-1:0]       rd_addr_i,
  output logic [2*ADC_DATA_WIDTH-1:0] rd_data_o,
  output logic                        rd_valid_o,
  output logic [1:0]                  state_o,
  output logic [ADDR_WIDTH:0]         wr_count_o,
  output logic                        done_o
);

  localparam logic [ADDR_WIDTH:0] LAST_CNT = {1'b0, {ADDR_WIDTH{1'b1}}};

  capture_state_t               r_state;
  logic [ADDR_WIDTH:0]          r_wr_count;
  logic [DECIM_WIDTH-1:0]       r_decim;
  logic [DECIM_WIDTH-1:0]       r_decim_cnt;
  logic                         r_rd_valid;

  logic                         w_trig;
  logic                         w_wr_en;
  logic [ADDR_WIDTH-1:0]        w_wr_addr;
  logic [2*ADC_DATA_WIDTH-1:0]  w_wr_data;

`ifdef PDH_CAPTURE_TRIG_EN
  logic [ADC_DATA_WIDTH-1:0]    r_prev_a;
  logic                         r_hist_ok;

  // r_hist_ok stays low for the first ARMED cycle so a stale sample cannot trigger.
  assign w_trig = r_hist_ok
               && ($signed(r_prev_a) < $signed(trig_level_i))
               && ($signed(adc_dat_a_i) >= $signed(trig_level_i));
`else
  logic w_unused_trig;

  assign w_trig        = 1'b1;
  assign w_unused_trig = ^trig_level_i;
`endif

  // Abort and re-arm both pre-empt a pending write so the count stays consistent.
  assign w_wr_en   = (r_state == ST_CAPTURE) && (r_decim_cnt == '0) && !abort_i && !arm_i;
  assign w_wr_addr = r_wr_count[ADDR_WIDTH-1:0];
  assign w_wr_data = {adc_dat_b_i, adc_dat_a_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_wr_count  <= '0;
      r_decim     <= '0;
      r_decim_cnt <= '0;
      r_rd_valid  <= 1'b0;
`ifdef PDH_CAPTURE_TRIG_EN
      r_prev_a    <= '0;
      r_hist_ok   <= 1'b0;
`endif
    end else begin
      r_rd_valid <= rd_en_i;
      if (abort_i) begin
        r_state <= ST_IDLE;
      end else if (arm_i) begin
        r_state     <= ST_ARMED;
        r_wr_count  <= '0;
        r_decim     <= decim_i;
        r_decim_cnt <= '0;
`ifdef PDH_CAPTURE_TRIG_EN
        r_hist_ok   <= 1'b0;
`endif
      end else begin
        case (r_state)
          ST_ARMED: begin
`ifdef PDH_CAPTURE_TRIG_EN
            r_prev_a  <= adc_dat_a_i;
            r_hist_ok <= 1'b1;
`endif
            if (w_trig) begin
              r_state     <= ST_CAPTURE;
              r_decim_cnt <= '0;
            end
          end
          ST_CAPTURE: begin
            if (r_decim_cnt == '0) begin
              r_wr_count  <= r_wr_count + (ADDR_WIDTH+1)'(1);
              r_decim_cnt <= r_decim;
              if (r_wr_count == LAST_CNT) begin
                r_state <= ST_DONE;
              end
            end else begin
              r_decim_cnt <= r_decim_cnt - DECIM_WIDTH'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  capture_ram #(
    .DATA_WIDTH (2*ADC_DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (w_wr_en),
    .wr_addr_i (w_wr_addr),
    .wr_data_i (w_wr_data),
    .rd_en_i   (rd_en_i),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (rd_data_o)
  );

  assign rd_valid_o = r_rd_valid;
  assign state_o    = r_state;
  assign wr_count_o = r_wr_count;
  assign done_o     = (r_state == ST_DONE);

endmodule

// File: tb/tb_adc_capture.sv
// Self-checking bench for adc_capture: ramp captures, decimation, abort/restart,
// read-first collisions, asynchronous reset and the optional trigger.
module tb_adc_capture;

  localparam int W     = 14;
  localparam int AW    = 10;
  localparam int DW    = 16;
  localparam int DEPTH = 1 << AW;
`ifdef PDH_CAPTURE_TRIG_EN
  localparam int TL = 1;
`else
  localparam int TL = 0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [W-1:0]    adc_a, adc_b;
  logic            arm, abort, rd_en;
  logic [DW-1:0]   decim;
  logic [W-1:0]    trig_level;
  logic [AW-1:0]   rd_addr;
  logic [2*W-1:0]  rd_data_o;
  logic            rd_valid_o;
  logic [1:0]      state_o;
  logic [AW:0]     wr_count_o;
  logic            done_o;

  logic            ramp_on;
  int              tests  = 0;
  int              failed = 0;
  logic [2*W-1:0]  exp_q[$];

  always #5 clk = ~clk;

  adc_capture #(.ADC_DATA_WIDTH(W), .ADDR_WIDTH(AW), .DECIM_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .adc_dat_a_i(adc_a), .adc_dat_b_i(adc_b),
    .arm_i(arm), .abort_i(abort), .decim_i(decim), .trig_level_i(trig_level),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data_o),
    .rd_valid_o(rd_valid_o), .state_o(state_o), .wr_count_o(wr_count_o), .done_o(done_o)
  );

  function automatic logic [2*W-1:0] exp_word(input logic [W-1:0] a);
    return {a ^ 14'h1555, a};
  endfunction

  task automatic set_a(input logic [W-1:0] v);
    adc_a = v;
    adc_b = v ^ 14'h1555;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (ramp_on) set_a(adc_a + 14'd1);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // A at the arm edge is a0; the first stored sample is a0+2 (+1 with trigger).
  task automatic arm_capture(input logic [W-1:0] a0, input logic [DW-1:0] d);
    ramp_on    = 1'b1;
    set_a(a0);
    trig_level = a0 + 14'd2;
    decim      = d;
    arm        = 1'b1;
    tick();
    arm        = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if (state_o !== 2'd0 || wr_count_o !== '0 || done_o !== 1'b0 || rd_valid_o !== 1'b0 || rd_data_o !== '0) begin
      failed++;
      $display("FAIL reset_state: state=%0d wr=%0d done=%b vld=%b data=%h, want all 0", state_o, wr_count_o, done_o, rd_valid_o, rd_data_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

`ifdef PDH_CAPTURE_TRIG_EN
  task automatic test_trigger();
    logic [2*W-1:0] exp_w;
    ramp_on = 1'b0;
    decim = '0;
    trig_level = 14'd100;
    set_a(14'd90);
    arm = 1'b1; tick(); arm = 1'b0;
    set_a(14'd110); tick();
    tests++;
    if (state_o !== 2'd1) begin failed++; $display("FAIL trig_first_cycle: state=%0d want 1", state_o); end
    set_a(14'd90); tick(); tick();
    tests++;
    if (state_o !== 2'd1) begin failed++; $display("FAIL trig_falling: state=%0d want 1", state_o); end
    set_a(14'd110); tick();
    tests++;
    if (state_o !== 2'd2 || wr_count_o !== '0) begin failed++; $display("FAIL trig_rising: state=%0d wr=%0d want 2/0", state_o, wr_count_o); end
    tick();
    do_abort();
    rd_en = 1'b1; rd_addr = '0;
    exp_q.push_back(exp_word(14'd110));
    tick(); rd_en = 1'b0;
    exp_w = exp_q.pop_front();
    tests++;
    if (rd_valid_o !== 1'b1 || rd_data_o !== exp_w) begin failed++; $display("FAIL trig_sample: vld=%b data=%h want 1/%h", rd_valid_o, rd_data_o, exp_w); end
    // Signed crossing: -20 -> 5 across level -10.
    trig_level = 14'h3FF6;
    set_a(14'h3FEC);
    arm = 1'b1; tick(); arm = 1'b0;
    tick(); tick();
    tests++;
    if (state_o !== 2'd1) begin failed++; $display("FAIL trig_neg_hold: state=%0d want 1", state_o); end
    set_a(14'd5); tick();
    tests++;
    if (state_o !== 2'd2) begin failed++; $display("FAIL trig_signed: state=%0d want 2", state_o); end
    do_abort();
  endtask
`else
  task automatic test_no_trigger();
    ramp_on = 1'b0;
    decim = '0;
    set_a(14'd0);
    trig_level = 14'h1FFF;
    arm = 1'b1; tick(); arm = 1'b0;
    tests++;
    if (state_o !== 2'd1 || wr_count_o !== '0) begin failed++; $display("FAIL notrig_armed: state=%0d wr=%0d want 1/0", state_o, wr_count_o); end
    tick();
    tests++;
    if (state_o !== 2'd2) begin failed++; $display("FAIL notrig_capture: state=%0d want 2", state_o); end
    do_abort();
  endtask
`endif

  task automatic test_ramp_decim0();
    logic [2*W-1:0] exp_w;
    arm_capture(14'd0, 16'd0);
    tests++;
    if (state_o !== 2'd1 || wr_count_o !== '0) begin failed++; $display("FAIL ramp_armed: state=%0d wr=%0d want 1/0", state_o, wr_count_o); end
    tick_n(TL + 1);
    tests++;
    if (state_o !== 2'd2 || wr_count_o !== '0) begin failed++; $display("FAIL ramp_enter: state=%0d wr=%0d want 2/0", state_o, wr_count_o); end
    tick_n(DEPTH - 1);
    tests++;
    if (state_o !== 2'd2 || wr_count_o !== 11'd1023 || done_o !== 1'b0) begin failed++; $display("FAIL ramp_last: state=%0d wr=%0d done=%b want 2/1023/0", state_o, wr_count_o, done_o); end
    tick();
    tests++;
    if (state_o !== 2'd3 || wr_count_o !== 11'd1024 || done_o !== 1'b1) begin failed++; $display("FAIL ramp_done: state=%0d wr=%0d done=%b want 3/1024/1", state_o, wr_count_o, done_o); end
    tick_n(5);
    tests++;
    if (state_o !== 2'd3 || wr_count_o !== 11'd1024) begin failed++; $display("FAIL ramp_hold: state=%0d wr=%0d want 3/1024", state_o, wr_count_o); end
    ramp_on = 1'b0;
    exp_w = '0;
    for (int k = 0; k < DEPTH; k++) begin
      rd_en = 1'b1; rd_addr = AW'(k);
      exp_q.push_back(exp_word(W'(2 + TL + k)));
      tick();
      exp_w = exp_q.pop_front();
      tests++;
      if (rd_valid_o !== 1'b1 || rd_data_o !== exp_w) begin failed++; $display("FAIL ramp_rd[%0d]: vld=%b data=%h want 1/%h", k, rd_valid_o, rd_data_o, exp_w); end
    end
    rd_en = 1'b0;
    tick();
    tests++;
    if (rd_valid_o !== 1'b0 || rd_data_o !== exp_w) begin failed++; $display("FAIL rd_hold: vld=%b data=%h want 0/%h", rd_valid_o, rd_data_o, exp_w); end
  endtask

  task automatic test_decim3();
    logic [2*W-1:0] exp_w;
    arm_capture(14'd0, 16'd3);
    decim = 16'd0;
    tick_n(TL + 1);
    tests++;
    if (state_o !== 2'd2) begin failed++; $display("FAIL dec3_enter: state=%0d want 2", state_o); end
    tick_n(4092);
    tests++;
    if (state_o !== 2'd2 || wr_count_o !== 11'd1023) begin failed++; $display("FAIL dec3_last: state=%0d wr=%0d want 2/1023", state_o, wr_count_o); end
    tick();
    tests++;
    if (state_o !== 2'd3 || wr_count_o !== 11'd1024) begin failed++; $display("FAIL dec3_done: state=%0d wr=%0d want 3/1024", state_o, wr_count_o); end
    ramp_on = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      rd_en = 1'b1; rd_addr = AW'(k);
      exp_q.push_back(exp_word(W'(2 + TL + 4 * k)));
      tick();
      exp_w = exp_q.pop_front();
      tests++;
      if (rd_valid_o !== 1'b1 || rd_data_o !== exp_w) begin failed++; $display("FAIL dec3_rd[%0d]: vld=%b data=%h want 1/%h", k, rd_valid_o, rd_data_o, exp_w); end
    end
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    logic [2*W-1:0] exp_w;
    arm_capture(14'd0, 16'd0);
    tick_n(TL + 1 + 500);
    tests++;
    if (state_o !== 2'd2 || wr_count_o !== 11'd500) begin failed++; $display("FAIL abort_pre: state=%0d wr=%0d want 2/500", state_o, wr_count_o); end
    abort = 1'b1; arm = 1'b1;
    tick();
    abort = 1'b0; arm = 1'b0;
    tests++;
    if (state_o !== 2'd0 || wr_count_o !== 11'd500 || done_o !== 1'b0) begin failed++; $display("FAIL abort_arm: state=%0d wr=%0d want 0/500", state_o, wr_count_o); end
    tick_n(3);
    tests++;
    if (state_o !== 2'd0 || rd_valid_o !== 1'b0) begin failed++; $display("FAIL abort_idle: state=%0d vld=%b want 0/0", state_o, rd_valid_o); end
    rd_en = 1'b1; rd_addr = 10'd10;
    exp_q.push_back(exp_word(W'(2 + TL + 10)));
    tick(); rd_en = 1'b0;
    exp_w = exp_q.pop_front();
    tests++;
    if (rd_valid_o !== 1'b1 || rd_data_o !== exp_w) begin failed++; $display("FAIL abort_rd10: vld=%b data=%h want 1/%h", rd_valid_o, rd_data_o, exp_w); end
    tick();
    tests++;
    if (rd_valid_o !== 1'b0) begin failed++; $display("FAIL abort_vld_drop: vld=%b want 0", rd_valid_o); end
  endtask

  task automatic test_read_first();
    logic [2*W-1:0] exp_w;
    arm_capture(14'd1000, 16'd0);
    tick_n(TL + 1 + 5);
    tests++;
    if (state_o !== 2'd2 || wr_count_o !== 11'd5) begin failed++; $display("FAIL rf_pre: state=%0d wr=%0d want 2/5", state_o, wr_count_o); end
    rd_en = 1'b1; rd_addr = 10'd5;
    exp_q.push_back(exp_word(W'(2 + TL + 5)));
    tick(); rd_en = 1'b0;
    exp_w = exp_q.pop_front();
    tests++;
    if (rd_valid_o !== 1'b1 || rd_data_o !== exp_w) begin failed++; $display("FAIL rf_collide: vld=%b data=%h want 1/%h", rd_valid_o, rd_data_o, exp_w); end
    do_abort();
    tests++;
    if (state_o !== 2'd0 || wr_count_o !== 11'd6) begin failed++; $display("FAIL rf_abort: state=%0d wr=%0d want 0/6", state_o, wr_count_o); end
    rd_en = 1'b1; rd_addr = 10'd5;
    exp_q.push_back(exp_word(W'(1000 + 2 + TL + 5)));
    tick();
    exp_w = exp_q.pop_front();
    tests++;
    if (rd_valid_o !== 1'b1 || rd_data_o !== exp_w) begin failed++; $display("FAIL rf_new5: vld=%b data=%h want 1/%h", rd_valid_o, rd_data_o, exp_w); end
    rd_addr = 10'd6;
    exp_q.push_back(exp_word(W'(2 + TL + 6)));
    tick(); rd_en = 1'b0;
    exp_w = exp_q.pop_front();
    tests++;
    if (rd_valid_o !== 1'b1 || rd_data_o !== exp_w) begin failed++; $display("FAIL rf_old6: vld=%b data=%h want 1/%h", rd_valid_o, rd_data_o, exp_w); end
  endtask

  task automatic test_restart();
    logic [2*W-1:0] exp_w;
    arm_capture(14'd0, 16'd0);
    tick_n(TL + 1 + 20);
    tests++;
    if (state_o !== 2'd2 || wr_count_o !== 11'd20) begin failed++; $display("FAIL rs_pre: state=%0d wr=%0d want 2/20", state_o, wr_count_o); end
    arm_capture(14'd0, 16'd1);
    tests++;
    if (state_o !== 2'd1 || wr_count_o !== '0) begin failed++; $display("FAIL rs_rearm: state=%0d wr=%0d want 1/0", state_o, wr_count_o); end
    tick_n(TL + 1);
    tick();
    tests++;
    if (state_o !== 2'd2 || wr_count_o !== 11'd1) begin failed++; $display("FAIL rs_w0: state=%0d wr=%0d want 2/1", state_o, wr_count_o); end
    tick();
    tests++;
    if (wr_count_o !== 11'd1) begin failed++; $display("FAIL rs_skip: wr=%0d want 1", wr_count_o); end
    tick();
    tests++;
    if (wr_count_o !== 11'd2) begin failed++; $display("FAIL rs_w1: wr=%0d want 2", wr_count_o); end
    rd_en = 1'b1; rd_addr = 10'd1;
    exp_q.push_back(exp_word(W'(4 + TL)));
    tick(); rd_en = 1'b0;
    exp_w = exp_q.pop_front();
    tests++;
    if (rd_valid_o !== 1'b1 || rd_data_o !== exp_w) begin failed++; $display("FAIL rs_rd1: vld=%b data=%h want 1/%h", rd_valid_o, rd_data_o, exp_w); end
    do_abort();
  endtask

  task automatic test_reset_mid();
    logic [2*W-1:0] exp_w;
    arm_capture(14'd0, 16'd0);
    tick_n(TL + 1 + 300);
    tests++;
    if (state_o !== 2'd2 || wr_count_o !== 11'd300) begin failed++; $display("FAIL rm_pre: state=%0d wr=%0d want 2/300", state_o, wr_count_o); end
    rd_en = 1'b1; rd_addr = 10'd7;
    exp_q.push_back(exp_word(W'(2 + TL + 7)));
    tick(); rd_en = 1'b0;
    exp_w = exp_q.pop_front();
    tests++;
    if (rd_valid_o !== 1'b1 || rd_data_o !== exp_w) begin failed++; $display("FAIL rm_rd7: vld=%b data=%h want 1/%h", rd_valid_o, rd_data_o, exp_w); end
    rst_n = 1'b0;
    #1;
    tests++;
    if (state_o !== 2'd0 || wr_count_o !== '0 || done_o !== 1'b0) begin failed++; $display("FAIL rm_async_state: state=%0d wr=%0d done=%b want 0/0/0", state_o, wr_count_o, done_o); end
    tests++;
    if (rd_valid_o !== 1'b0 || rd_data_o !== '0) begin failed++; $display("FAIL rm_async_rd: vld=%b data=%h want 0/0", rd_valid_o, rd_data_o); end
    @(negedge clk);
    rst_n = 1'b1;
    arm_capture(14'd500, 16'd0);
    tests++;
    if (state_o !== 2'd1 || wr_count_o !== '0) begin failed++; $display("FAIL rm_rearm: state=%0d wr=%0d want 1/0", state_o, wr_count_o); end
    tick_n(TL + 2);
    tests++;
    if (state_o !== 2'd2 || wr_count_o !== 11'd1) begin failed++; $display("FAIL rm_w0: state=%0d wr=%0d want 2/1", state_o, wr_count_o); end
    rd_en = 1'b1; rd_addr = 10'd0;
    exp_q.push_back(exp_word(W'(500 + 2 + TL)));
    tick(); rd_en = 1'b0;
    exp_w = exp_q.pop_front();
    tests++;
    if (rd_valid_o !== 1'b1 || rd_data_o !== exp_w) begin failed++; $display("FAIL rm_rd0: vld=%b data=%h want 1/%h", rd_valid_o, rd_data_o, exp_w); end
    do_abort();
  endtask

  initial begin
    rst_n = 1'b0; arm = 1'b0; abort = 1'b0; rd_en = 1'b0; rd_addr = '0;
    decim = '0; trig_level = '0; ramp_on = 1'b0;
    set_a(14'd0);
    test_reset();
`ifdef PDH_CAPTURE_TRIG_EN
    test_trigger();
`else
    test_no_trigger();
`endif
    test_ramp_decim0();
    test_decim3();
    test_abort();
    test_read_first();
    test_restart();
    test_reset_mid();
    tests++;
    if (exp_q.size() != 0) begin failed++; $display("FAIL scoreboard_empty: %0d left want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
